// File: rtl/cpu_obi_mux_pkg.sv
// Shared types and defaults for the multi-hart OBI aggregator.
package cpu_obi_mux_pkg;

  localparam int unsigned NumCpuCores       = 2;
  localparam int unsigned CpuMaxOutstanding = 2;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cpu_obi_mux_idfifo.sv
// In-order ID FIFO recording which hart owns each outstanding bus transaction.
module cpu_obi_mux_idfifo
  import cpu_obi_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the same cycle, so push is accepted even when full.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
      if (do_pop)  rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cpu_obi_mux.sv
// Merges NUM_CORES hart OBI ports onto one bus master and routes in-order responses back.
// CPU_OBI_MUX_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module cpu_obi_mux
  import cpu_obi_mux_pkg::*;
#(
  parameter int unsigned NUM_CORES       = NumCpuCores,
  parameter int unsigned MAX_OUTSTANDING = CpuMaxOutstanding
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  obi_req_t  [NUM_CORES-1:0] core_req_i,
  output obi_resp_t [NUM_CORES-1:0] core_resp_o,
  output obi_req_t                  bus_req_o,
  input  obi_resp_t                 bus_resp_i
);

  localparam int unsigned IDX_W = $clog2(NUM_CORES > 1 ? NUM_CORES : 2);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic [IDX_W-1:0] sel;
  logic             winner;
  logic             present;
  logic             handshake;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] head;
  logic [CNT_W-1:0] fifo_count;

`ifdef CPU_OBI_MUX_FIXED_PRIO_EN
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!arb_found && core_req_i[IDX_W'(i)].req) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_q;
  int unsigned      cand;

  always_comb begin
    arb_idx   = rr_q;
    arb_found = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!arb_found && core_req_i[IDX_W'(cand)].req) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        rr_q <= '0;
    else if (handshake) rr_q <= IDX_W'(wrap_inc(32'(sel), NUM_CORES));
  end
`endif

  // A presented but ungranted request pins the selection so it is never retracted.
  always_comb begin
    if (state_q == ARB_LOCKED) begin
      sel    = lock_idx_q;
      winner = core_req_i[lock_idx_q].req;
    end else begin
      sel    = arb_idx;
      winner = arb_found;
    end
  end

  assign present   = winner & ~fifo_full;
  assign handshake = present & bus_resp_i.gnt;
  assign pop       = bus_resp_i.rvalid & ~fifo_empty;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    if (present && !bus_resp_i.gnt) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = sel;
    end else if (handshake) begin
      state_d = ARB_OPEN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_OPEN;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    bus_req_o = present ? core_req_i[sel] : '0;
  end

  always_comb begin
    core_resp_o          = '0;
    core_resp_o[sel].gnt = handshake;
    if (pop) begin
      core_resp_o[head].rvalid = 1'b1;
      core_resp_o[head].rdata  = bus_resp_i.rdata;
    end
  end

  cpu_obi_mux_idfifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_idfifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (handshake),
    .pop   (pop),
    .wdata (sel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head),
    .count (fifo_count)
  );

  a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus_req_o.req && !bus_resp_i.gnt) |=> $stable(bus_req_o));

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(fifo_count) <= MAX_OUTSTANDING);

  a_no_orphan_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus_resp_i.rvalid && fifo_empty));

endmodule

// File: tb/tb_cpu_obi_mux.sv
// Scoreboard bench for cpu_obi_mux: directed hart/bus stimulus, decoupled grant/response monitor.
module tb_cpu_obi_mux;
  import cpu_obi_mux_pkg::*;

  localparam int NC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  obi_req_t  [NC-1:0] core_req;
  obi_resp_t [NC-1:0] core_resp;
  obi_req_t           bus_req;
  obi_resp_t          bus_resp;

  always #5 clk = ~clk;

  cpu_obi_mux #(
    .NUM_CORES       (NC),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .core_req_i  (core_req),
    .core_resp_o (core_resp),
    .bus_req_o   (bus_req),
    .bus_resp_i  (bus_resp)
  );

  typedef struct {
    int unsigned hart;
    logic [31:0] data;
  } exp_t;

  exp_t exp_gnt[$];
  exp_t exp_rsp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
    end
  endtask

  // Monitor: every grant / rvalid the DUT presents is matched against the queues.
  always @(negedge clk) begin : monitor
    int   ng, nr, gh, rh;
    exp_t e;
    if (rst_n) begin
      ng = 0; nr = 0; gh = 0; rh = 0;
      for (int h = 0; h < NC; h++) begin
        if (core_resp[h].gnt)    begin ng++; gh = h; end
        if (core_resp[h].rvalid) begin nr++; rh = h; end
      end
      if (ng != 0) begin
        check("gnt_onehot", ng, 1);
        if (exp_gnt.size() == 0) check("gnt_unexpected", ng, 0);
        else begin
          e = exp_gnt.pop_front();
          check("gnt_hart", gh, e.hart);
          check("gnt_addr", bus_req.addr, e.data);
        end
      end
      if (nr != 0) begin
        check("rvalid_onehot", nr, 1);
        for (int h = 0; h < NC; h++)
          if (h != rh) check($sformatf("rdata_idle_h%0d", h), core_resp[h].rdata, 0);
        if (exp_rsp.size() == 0) check("rvalid_unexpected", nr, 0);
        else begin
          e = exp_rsp.pop_front();
          check("rvalid_hart", rh, e.hart);
          check("rvalid_rdata", core_resp[rh].rdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = '0;
    bus_resp = '0;
  endtask

  task automatic set_req(input int h, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    core_req[h].req   = 1'b1;
    core_req[h].addr  = addr;
    core_req[h].we    = we;
    core_req[h].be    = 4'hF;
    core_req[h].wdata = wdata;
  endtask

  task automatic drop(input int h);
    core_req[h] = '0;
  endtask

  task automatic push_gnt(input int unsigned h, input logic [31:0] a);
    exp_t e;
    e.hart = h; e.data = a;
    exp_gnt.push_back(e);
  endtask

  task automatic push_rsp(input int unsigned h, input logic [31:0] d);
    exp_t e;
    e.hart = h; e.data = d;
    exp_rsp.push_back(e);
    bus_resp.rvalid = 1'b1;
    bus_resp.rdata  = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    exp_gnt.delete();
    exp_rsp.delete();
    tick();
    tick();
    check("rst_bus_req_zero", 32'(bus_req == '0), 1);
    check("rst_core_resp_zero", 32'(core_resp == '0), 1);
    rst_n = 1'b1;
    tick();
    check("post_rst_bus_req_zero", 32'(bus_req == '0), 1);
    check("post_rst_core_resp_zero", 32'(core_resp == '0), 1);
  endtask

  task automatic drained(input string tag);
    check({tag, "_gnt_queue_drained"}, exp_gnt.size(), 0);
    check({tag, "_rsp_queue_drained"}, exp_rsp.size(), 0);
  endtask

  initial begin : stim
    int unsigned ord [4];
    idle_inputs();

    // 1: single hart, rvalid two cycles after grant
    do_reset();
    set_req(0, 32'h180, 1'b0, 32'h0);
    bus_resp.gnt = 1'b1;
    push_gnt(0, 32'h180);
    tick();
    drop(0);
    bus_resp = '0;
    tick();
    push_rsp(0, 32'hDEADBEEF);
    #1 check("t1_hart1_rvalid_low", core_resp[1].rvalid, 0);
    tick();
    idle_inputs();
    tick();
    drained("t1");

    // 2: continuous contention, bus grants every cycle, responses one cycle later
    do_reset();
`ifdef CPU_OBI_MUX_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0};
`else
    ord = '{0, 1, 0, 1};
`endif
    set_req(0, 32'h1000, 1'b0, 32'h0);
    set_req(1, 32'h2000, 1'b0, 32'h0);
    bus_resp.gnt = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) push_gnt(ord[k], (ord[k] == 1) ? 32'h2000 : 32'h1000);
      else begin
        drop(0);
        drop(1);
        bus_resp.gnt = 1'b0;
      end
      if (k > 0) push_rsp(ord[k-1], 32'hA000_0000 + 32'(k));
      tick();
    end
    idle_inputs();
    tick();
    drained("t2");

    // 3: hart1 stalled on the bus must not be displaced by hart0
    do_reset();
    set_req(1, 32'h3000, 1'b1, 32'h1111_2222);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_req(0, 32'h4000, 1'b0, 32'h0);
      #1;
      check($sformatf("t3_lock_req_c%0d", c), bus_req.req, 1);
      check($sformatf("t3_lock_addr_c%0d", c), bus_req.addr, 32'h3000);
      check($sformatf("t3_lock_wdata_c%0d", c), bus_req.wdata, 32'h1111_2222);
      tick();
    end
    bus_resp.gnt = 1'b1;
    push_gnt(1, 32'h3000);
    tick();
    drop(1);
    push_gnt(0, 32'h4000);
    tick();
    drop(0);
    bus_resp.gnt = 1'b0;
    push_rsp(1, 32'hC3C3_0001);
    tick();
    push_rsp(0, 32'hC3C3_0002);
    tick();
    idle_inputs();
    tick();
    drained("t3");

    // 4: outstanding limit gates the request, even when a response pops that cycle
    do_reset();
    bus_resp.gnt = 1'b1;
    set_req(0, 32'h5000, 1'b0, 32'h0);
    push_gnt(0, 32'h5000);
    tick();
    set_req(0, 32'h5004, 1'b0, 32'h0);
    push_gnt(0, 32'h5004);
    tick();
    set_req(0, 32'h5008, 1'b0, 32'h0);
    #1 check("t4_full_gate", bus_req.req, 0);
    tick();
    push_rsp(0, 32'hB0);
    #1 check("t4_full_gate_with_pop", bus_req.req, 0);
    tick();
    bus_resp.rvalid = 1'b0;
    bus_resp.rdata  = '0;
    push_gnt(0, 32'h5008);
    #1;
    check("t4_represent_req", bus_req.req, 1);
    check("t4_represent_addr", bus_req.addr, 32'h5008);
    tick();
    drop(0);
    bus_resp.gnt = 1'b0;
    push_rsp(0, 32'hB1);
    tick();
    push_rsp(0, 32'hB2);
    tick();
    idle_inputs();
    tick();
    drained("t4");

    // 5: grant to hart1 and response to hart0 in the same cycle
    do_reset();
    bus_resp.gnt = 1'b1;
    set_req(0, 32'h6000, 1'b0, 32'h0);
    push_gnt(0, 32'h6000);
    tick();
    drop(0);
    set_req(1, 32'h7000, 1'b0, 32'h0);
    push_gnt(1, 32'h7000);
    push_rsp(0, 32'hC0);
    tick();
    drop(1);
    bus_resp.gnt = 1'b0;
    push_rsp(1, 32'hC1);
    tick();
    bus_resp = '0;
    bus_resp.gnt = 1'b1;
    set_req(0, 32'h6100, 1'b0, 32'h0);
    push_gnt(0, 32'h6100);
    tick();
    set_req(0, 32'h6104, 1'b0, 32'h0);
    push_gnt(0, 32'h6104);
    tick();
    set_req(0, 32'h6108, 1'b0, 32'h0);
    #1 check("t5_count_after_swap", bus_req.req, 0);
    tick();
    drop(0);
    bus_resp.gnt = 1'b0;
    push_rsp(0, 32'hD0);
    tick();
    push_rsp(0, 32'hD1);
    tick();
    idle_inputs();
    tick();
    drained("t5");

    // 6: reset with two transactions outstanding clears the tracking state
    do_reset();
    bus_resp.gnt = 1'b1;
    set_req(0, 32'h8000, 1'b0, 32'h0);
    set_req(1, 32'h9000, 1'b0, 32'h0);
    push_gnt(0, 32'h8000);
    tick();
    drop(0);
    push_gnt(1, 32'h9000);
    tick();
    do_reset();
    bus_resp.gnt = 1'b1;
    set_req(1, 32'hA0, 1'b0, 32'h0);
    push_gnt(1, 32'hA0);
    tick();
    set_req(1, 32'hA4, 1'b0, 32'h0);
    push_gnt(1, 32'hA4);
    #1 check("t6_fifo_cleared", bus_req.req, 1);
    tick();
    drop(1);
    bus_resp.gnt = 1'b0;
    push_rsp(1, 32'hE0);
    tick();
    push_rsp(1, 32'hE1);
    tick();
    idle_inputs();
    tick();
    drained("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
